// File: rtl/pc_ctrl_pkg.sv
// Shared types and widths for the program-counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_ctrl_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ILLEGAL  = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } cause_t;

endpackage

// File: rtl/pc_next_select.sv
// Next-PC priority mux: trap > misaligned target > halt > jalr > branch > sequential.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller gates the result with the fetch handshake.
module pc_next_select
    import pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VECTOR = 64'h100
) (
    input  logic [XLEN-1:0] pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap,
    input  logic            halt,
    output logic [XLEN-1:0] next_pc,
    output logic            take_trap,
    output cause_t          trap_cause,
    output logic            retire
);

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] sel_tgt;
    logic            redirect;
    logic            misalign;

    // jalr always discards bit 0 before the target is used or checked
    assign jalr_tgt = jalr_target & ~XLEN'(1);
    assign pc_plus4 = pc + XLEN'(4);
    assign redirect = jalr | branch_taken;
    // jalr outranks branch, so its target is the one checked for alignment
    assign sel_tgt  = jalr ? jalr_tgt : branch_target;
    assign misalign = redirect && (sel_tgt[1:0] != 2'b00);

    // Priority resolution of the committing instruction's successor
    always_comb begin
        next_pc    = pc_plus4;
        take_trap  = 1'b0;
        trap_cause = CAUSE_NONE;
        retire     = 1'b1;
        if (trap) begin
            next_pc    = TRAP_VECTOR;
            take_trap  = 1'b1;
            trap_cause = CAUSE_ILLEGAL;
            retire     = 1'b0;
        end else if (misalign) begin
            next_pc    = TRAP_VECTOR;
            take_trap  = 1'b1;
            trap_cause = CAUSE_MISALIGN;
            retire     = 1'b0;
        end else if (halt) begin
            next_pc = pc_plus4;
        end else if (jalr) begin
            next_pc = jalr_tgt;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_controller.sv
// Program-counter sequencer: boot, fetch handshake, halt/resume, trap capture, retire count.
// Latency: next PC is combinational; pc updates one clock after the commit cycle.
// Backpressure: imem_ready low stalls the PC (pc_enable=0) for as many cycles as it stays low.
module pc_controller
    import pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 64'h100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_in,
    output logic              pc_enable,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    input  logic              jalr,
    input  logic [XLEN-1:0]   jalr_target,
    input  logic              trap,
    input  logic              halt,
    input  logic              resume,
    output logic [XLEN-1:0]   epc,
    output logic [1:0]        cause,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  retired_count
);

    pc_state_t         state_q;
    pc_state_t         state_d;
    logic [XLEN-1:0]   epc_q;
    cause_t            cause_q;
    logic [CNT_W-1:0]  retired_cnt_q;

    logic [XLEN-1:0]   sel_pc;
    logic              take_trap;
    cause_t            trap_cause;
    logic              retire;
    logic              commit;
    logic [XLEN-1:0]   pc_plus4;

    pc_next_select #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_select (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jalr          (jalr),
        .jalr_target   (jalr_target),
        .trap          (trap),
        .halt          (halt),
        .next_pc       (sel_pc),
        .take_trap     (take_trap),
        .trap_cause    (trap_cause),
        .retire        (retire)
    );

    assign pc_plus4 = pc + XLEN'(4);
    // An instruction commits only when fetched and valid in FETCH
    assign commit   = (state_q == FETCH) && imem_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: halt only wins when the instruction did not trap
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (commit && halt && !take_trap) state_d = HALT;
            HALT:    if (resume) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    // Mealy outputs to the PC register and instruction memory
    always_comb begin
        pc_in     = pc_plus4;
        pc_enable = 1'b0;
        imem_req  = 1'b0;
        case (state_q)
            BOOT: begin
                pc_in     = RESET_VECTOR;
                pc_enable = 1'b1;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    pc_enable = 1'b1;
                    pc_in     = sel_pc;
                end
            end
            default: ;
        endcase
    end

    // Trap record and retire counter, updated on the commit edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q         <= '0;
            cause_q       <= CAUSE_NONE;
            retired_cnt_q <= '0;
        end else if (commit) begin
            if (take_trap) begin
                epc_q   <= pc;
                cause_q <= trap_cause;
            end else if (retire) begin
                retired_cnt_q <= retired_cnt_q + CNT_W'(1);
            end
        end
    end

    assign epc           = epc_q;
    assign cause         = cause_q;
    assign state         = state_q;
    assign retired_count = retired_cnt_q;

endmodule

// File: tb/tb_pc_controller.sv
// Bench for pc_controller: emulates the PC register, checks every cycle against a reference model.
// Latency: n/a.
// Backpressure: imem_ready is driven both directed and random.
module tb_pc_controller;

    localparam logic [63:0] RV = 64'h40;
    localparam logic [63:0] TV = 64'h100;

    logic        clk;
    logic        reset;
    logic [63:0] pc;
    logic [63:0] pc_in;
    logic        pc_enable;
    logic        imem_req;
    logic        imem_ready;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        jalr;
    logic [63:0] jalr_target;
    logic        trap;
    logic        halt;
    logic        resume;
    logic [63:0] epc;
    logic [1:0]  cause;
    logic [1:0]  state;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;

    // Reference model state (0 boot, 1 fetch, 2 halt)
    int          m_state;
    logic [63:0] m_epc;
    logic [1:0]  m_cause;
    logic [31:0] m_cnt;
    // Model predictions for the current cycle
    logic [63:0] e_in;
    logic        e_en;
    logic        e_req;
    int          n_state;
    logic [63:0] n_epc;
    logic [1:0]  n_cause;
    logic [31:0] n_cnt;

    typedef struct {
        logic [63:0] pc0;
        bit          trp;
        bit          hlt;
        bit          jr;
        logic [63:0] jt;
        bit          br;
        logic [63:0] bt;
        logic [63:0] exp_pc;
        logic [1:0]  exp_state;
        logic [1:0]  exp_cause;
        logic [31:0] exp_ret;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    pc_controller #(
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pc_in         (pc_in),
        .pc_enable     (pc_enable),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jalr          (jalr),
        .jalr_target   (jalr_target),
        .trap          (trap),
        .halt          (halt),
        .resume        (resume),
        .epc           (epc),
        .cause         (cause),
        .state         (state),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_epc   = 64'h0;
        m_cause = 2'd0;
        m_cnt   = 32'h0;
    endtask

    // Architectural rules: what the next PC and records must be for this cycle
    task automatic model_eval();
        logic [63:0] tgt;
        bit          redirect;
        bit          bad;
        e_req   = 1'b0;
        e_en    = 1'b0;
        e_in    = pc + 64'd4;
        n_state = m_state;
        n_epc   = m_epc;
        n_cause = m_cause;
        n_cnt   = m_cnt;
        if (m_state == 0) begin
            e_en    = 1'b1;
            e_in    = RV;
            n_state = 1;
        end else if (m_state == 2) begin
            if (resume) n_state = 1;
        end else if (m_state == 1) begin
            e_req = 1'b1;
            if (imem_ready) begin
                e_en     = 1'b1;
                redirect = jalr || branch_taken;
                tgt      = jalr ? (jalr_target - (jalr_target % 2)) : branch_target;
                bad      = redirect && ((tgt % 4) != 0);
                if (trap || bad) begin
                    e_in    = TV;
                    n_epc   = pc;
                    n_cause = trap ? 2'd1 : 2'd2;
                end else begin
                    n_cnt = m_cnt + 32'd1;
                    if (halt) begin
                        n_state = 2;
                        e_in    = pc + 64'd4;
                    end else if (redirect) begin
                        e_in = tgt;
                    end
                end
            end
        end else begin
            n_state = 0;
        end
    endtask

    // One clock: called at posedge+1 with inputs already applied
    task automatic cycle();
        logic        en_s;
        logic [63:0] in_s;
        #3;
        model_eval();
        check("imem_req", {63'h0, imem_req}, {63'h0, e_req});
        check("pc_enable", {63'h0, pc_enable}, {63'h0, e_en});
        check("pc_in", pc_in, e_in);
        en_s = pc_enable;
        in_s = pc_in;
        @(posedge clk);
        #1;
        if (en_s) pc = in_s;
        m_state = n_state;
        m_epc   = n_epc;
        m_cause = n_cause;
        m_cnt   = n_cnt;
        check("state", {62'h0, state}, 64'(m_state));
        check("epc", epc, m_epc);
        check("cause", {62'h0, cause}, {62'h0, m_cause});
        check("retired_count", {32'h0, retired_count}, {32'h0, m_cnt});
    endtask

    task automatic clear_inputs();
        imem_ready    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        jalr          = 1'b0;
        jalr_target   = 64'h0;
        trap          = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
    endtask

    function automatic logic [63:0] rand_tgt();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        logic [31:0] cnt0;

        vecs[0]  = '{64'h1000, 0, 0, 0, 64'h0,    0, 64'h0,    64'h1004, 2'd1, 2'd0, 32'd1};
        vecs[1]  = '{64'h1000, 0, 0, 0, 64'h0,    1, 64'h2000, 64'h2000, 2'd1, 2'd0, 32'd1};
        vecs[2]  = '{64'h1000, 0, 0, 0, 64'h0,    1, 64'h2002, TV,       2'd1, 2'd2, 32'd0};
        vecs[3]  = '{64'h1000, 0, 0, 1, 64'h3003, 0, 64'h0,    TV,       2'd1, 2'd2, 32'd0};
        vecs[4]  = '{64'h1000, 0, 0, 1, 64'h3001, 0, 64'h0,    64'h3000, 2'd1, 2'd0, 32'd1};
        vecs[5]  = '{64'h1000, 0, 0, 1, 64'h4000, 1, 64'h5000, 64'h4000, 2'd1, 2'd0, 32'd1};
        vecs[6]  = '{64'h1000, 0, 0, 1, 64'h4000, 1, 64'h5002, 64'h4000, 2'd1, 2'd0, 32'd1};
        vecs[7]  = '{64'h7000, 0, 1, 0, 64'h0,    1, 64'h6000, 64'h7004, 2'd2, 2'd0, 32'd1};
        vecs[8]  = '{64'h7000, 0, 1, 0, 64'h0,    1, 64'h6001, TV,       2'd1, 2'd2, 32'd0};
        vecs[9]  = '{64'h8000, 1, 0, 1, 64'h3002, 0, 64'h0,    TV,       2'd1, 2'd1, 32'd0};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 2'd1, 2'd0, 32'd1};

        clear_inputs();
        pc    = 64'h0;
        reset = 1'b0;
        model_reset();
        #1;
        check("reset state", {62'h0, state}, 64'd0);
        check("reset epc", epc, 64'h0);
        check("reset cause", {62'h0, cause}, 64'd0);
        check("reset count", {32'h0, retired_count}, 64'd0);
        check("reset pc_enable", {63'h0, pc_enable}, 64'd1);
        check("reset pc_in", pc_in, RV);
        check("reset imem_req", {63'h0, imem_req}, 64'd0);

        // Reset held three cycles, then boot and two commits
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b1;
        imem_ready = 1'b1;
        cycle();
        check("boot pc", pc, 64'h40);
        cycle();
        check("first commit pc", pc, 64'h44);
        cycle();
        check("second commit pc", pc, 64'h48);
        check("two retired", {32'h0, retired_count}, 64'd2);

        // Stall, then a taken branch
        imem_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("stall pc", pc, 64'h48);
        end
        imem_ready    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        cycle();
        check("branch pc", pc, 64'h200);
        branch_taken = 1'b0;

        // jalr aligned after bit-0 clear, then misaligned
        jalr        = 1'b1;
        jalr_target = 64'h301;
        cycle();
        check("jalr pc", pc, 64'h300);
        jalr_target = 64'h302;
        cycle();
        check("jalr misalign pc", pc, TV);
        check("jalr misalign epc", epc, 64'h300);
        check("jalr misalign cause", {62'h0, cause}, 64'd2);
        check("jalr misalign count", {32'h0, retired_count}, 64'd4);
        jalr = 1'b0;

        // trap beats halt and branch
        pc            = 64'h80;
        trap          = 1'b1;
        halt          = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        cycle();
        check("simul pc", pc, TV);
        check("simul epc", epc, 64'h80);
        check("simul cause", {62'h0, cause}, 64'd1);
        check("simul state", {62'h0, state}, 64'd1);
        trap         = 1'b0;
        halt         = 1'b0;
        branch_taken = 1'b0;

        // Halt, idle four cycles, resume, commit
        pc   = 64'h10;
        halt = 1'b1;
        cycle();
        check("halt pc", pc, 64'h14);
        check("halt state", {62'h0, state}, 64'd2);
        halt = 1'b0;
        repeat (4) begin
            cycle();
            check("halt imem_req", {63'h0, imem_req}, 64'd0);
            check("halt pc hold", pc, 64'h14);
        end
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        check("resume state", {62'h0, state}, 64'd1);
        cycle();
        check("post resume pc", pc, 64'h18);

        // PC wrap
        pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        check("pc wrap", pc, 64'h0);

        // Retire counter wrap
        imem_ready = 1'b0;
        force dut.retired_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check("count preset", {32'h0, retired_count}, 64'hFFFF_FFFF);
        imem_ready = 1'b1;
        cycle();
        check("count wrap", {32'h0, retired_count}, 64'h0);

        // Single-commit vector table
        for (int i = 0; i < NV; i++) begin
            clear_inputs();
            imem_ready    = 1'b1;
            pc            = vecs[i].pc0;
            trap          = vecs[i].trp;
            halt          = vecs[i].hlt;
            jalr          = vecs[i].jr;
            jalr_target   = vecs[i].jt;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].bt;
            cnt0          = retired_count;
            cycle();
            check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d state", i), {62'h0, state}, {62'h0, vecs[i].exp_state});
            check($sformatf("vec%0d retire", i), {32'h0, retired_count - cnt0}, {32'h0, vecs[i].exp_ret});
            if (vecs[i].exp_cause != 2'd0) begin
                check($sformatf("vec%0d cause", i), {62'h0, cause}, {62'h0, vecs[i].exp_cause});
                check($sformatf("vec%0d epc", i), epc, vecs[i].pc0);
            end
            if (vecs[i].exp_state == 2'd2) begin
                clear_inputs();
                resume = 1'b1;
                cycle();
            end
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            imem_ready    = ($urandom_range(0, 3) != 0);
            trap          = ($urandom_range(0, 9) == 0);
            halt          = ($urandom_range(0, 11) == 0);
            jalr          = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 4) == 0);
            resume        = ($urandom_range(0, 2) == 0);
            jalr_target   = rand_tgt();
            branch_target = rand_tgt();
            cycle();
        end

        // Reset asserted mid-stall takes effect without a clock edge
        clear_inputs();
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("async reset state", {62'h0, state}, 64'd0);
        check("async reset count", {32'h0, retired_count}, 64'd0);
        check("async reset pc_in", pc_in, RV);
        check("async reset pc_enable", {63'h0, pc_enable}, 64'd1);
        check("async reset imem_req", {63'h0, imem_req}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();
        check("reboot pc", pc, RV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
